// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tstrb/tlast/tuser/tdest/tid) with master and slave modports
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
) ();
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TID_WIDTH-1:0]     tid;
    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
    modport slave (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/axi4_stream_pkt_gen.sv
// axi4_stream_pkt_gen: AXI4-Stream packet source (clk_i, async rst_i, start_i/stop_i, frozen size/amount/gap/tdest/tid config, busy_o, pkts_sent_o, pkt_o master)
module axi4_stream_pkt_gen #(
    parameter int TDATA_WIDTH    = 32,
    parameter int TUSER_WIDTH    = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int MAX_PKT_BYTES  = 2048,
    parameter int PKT_SIZE_WIDTH = $clog2(MAX_PKT_BYTES) + 1,
    parameter int CNT_WIDTH      = 16,
    parameter int GAP_WIDTH      = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [PKT_SIZE_WIDTH-1:0] pkt_size_i,
    input  logic [CNT_WIDTH-1:0]      pkts_amount_i,
    input  logic [GAP_WIDTH-1:0]      gap_i,
    input  logic [TDEST_WIDTH-1:0]    tdest_i,
    input  logic [TID_WIDTH-1:0]      tid_i,
    output logic                      busy_o,
    output logic [CNT_WIDTH-1:0]      pkts_sent_o,
    axi4_stream_if.master             pkt_o
);
    localparam int B = TDATA_WIDTH / 8;
    localparam logic [PKT_SIZE_WIDTH-1:0] B_W   = PKT_SIZE_WIDTH'(B);
    localparam logic [PKT_SIZE_WIDTH-1:0] MAX_W = PKT_SIZE_WIDTH'(MAX_PKT_BYTES);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t                    state;
    logic [PKT_SIZE_WIDTH-1:0] cfg_size, word, nw, ns, lw, rem;
    logic [CNT_WIDTH-1:0]      cfg_amount, sent_nxt;
    logic [GAP_WIDTH-1:0]      cfg_gap, gap_cnt;
    logic [TDEST_WIDTH-1:0]    cfg_dest;
    logic [TID_WIDTH-1:0]      cfg_id;
    logic [7:0]                pkt, np, base;
    logic                      stop_pend, tvalid, tlast, sop, n_last;
    logic [TDATA_WIDTH-1:0]    tdata, n_data;
    logic [B-1:0]              tkeep, n_keep;
    logic                      hs, start_ok, done, load, go_gap;
    assign busy_o       = state != IDLE;
    assign pkt_o.tvalid = tvalid;
    assign pkt_o.tdata  = tdata;
    assign pkt_o.tkeep  = tkeep;
    assign pkt_o.tstrb  = tkeep;
    assign pkt_o.tlast  = tlast;
    assign pkt_o.tuser  = TUSER_WIDTH'(sop);
    assign pkt_o.tdest  = cfg_dest;
    assign pkt_o.tid    = cfg_id;
    // The next beat is computed from the (packet, word) pair it will carry; in IDLE the raw inputs stand in for the not-yet-latched config.
    always_comb begin
        hs       = tvalid && pkt_o.tready;
        nw       = (state == SEND && !tlast) ? word + 1'b1 : '0;
        np       = (state == IDLE) ? 8'd0 : (state == SEND && tlast) ? pkt + 8'd1 : pkt;
        ns       = (state == IDLE) ? pkt_size_i : cfg_size;
        lw       = (ns - 1'b1) / B_W;
        rem      = ns % B_W;
        base     = np + 8'(nw * B_W);
        n_last   = nw == lw;
        n_data   = '0;
        n_keep   = '0;
        for (int k = 0; k < B; k++) begin
            n_data[8*k +: 8] = base + 8'(k);
            n_keep[k]        = !n_last || rem == '0 || PKT_SIZE_WIDTH'(k) < rem;
        end
        sent_nxt = pkts_sent_o + 1'b1;
        start_ok = start_i && pkt_size_i != '0 && pkt_size_i <= MAX_W;
        done     = (cfg_amount != '0 && sent_nxt == cfg_amount) || stop_pend || stop_i;
        go_gap   = state == SEND && hs && tlast && !done && cfg_gap != '0;
        load     = (state == IDLE && start_ok)
                || (state == SEND && hs && (!tlast || (!done && cfg_gap == '0)))
                || (state == GAP && !(stop_pend || stop_i) && gap_cnt == GAP_WIDTH'(1));
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cfg_size    <= '0;
            cfg_amount  <= '0;
            cfg_gap     <= '0;
            cfg_dest    <= '0;
            cfg_id      <= '0;
            word        <= '0;
            pkt         <= '0;
            gap_cnt     <= '0;
            stop_pend   <= 1'b0;
            pkts_sent_o <= '0;
            tvalid      <= 1'b0;
            tdata       <= '0;
            tkeep       <= '0;
            tlast       <= 1'b0;
            sop         <= 1'b0;
        end else begin
            tvalid <= load || (tvalid && !(hs && tlast));
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (start_ok) begin
                        cfg_size    <= pkt_size_i;
                        cfg_amount  <= pkts_amount_i;
                        cfg_gap     <= gap_i;
                        cfg_dest    <= tdest_i;
                        cfg_id      <= tid_i;
                        pkts_sent_o <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (stop_i) stop_pend <= 1'b1;
                    if (hs && tlast) begin
                        pkts_sent_o <= sent_nxt;
                        state       <= done ? IDLE : go_gap ? GAP : SEND;
                        gap_cnt     <= cfg_gap;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    state   <= (stop_pend || stop_i) ? IDLE : load ? SEND : GAP;
                end
                default: state <= IDLE;
            endcase
            if (load || go_gap) pkt <= np;
            if (load) begin
                word  <= nw;
                tdata <= n_data;
                tkeep <= n_keep;
                tlast <= n_last;
                sop   <= nw == '0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
// tb_axi4_stream_pkt_gen: scoreboard bench for axi4_stream_pkt_gen with 32-bit tdata
module tb_axi4_stream_pkt_gen;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, rdy = 1'b1;
    logic [11:0] size = '0;
    logic [15:0] amt = '0;
    logic [7:0]  gap = '0;
    logic        dest = 1'b0, id = 1'b0, busy;
    logic [15:0] sent;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic        dest;
        logic        id;
        int          gap;
    } beat_t;
    beat_t q[$];
    int    checks = 0, errors = 0;
    bit    mon_en = 1'b1, rand_rdy = 1'b0;
    axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) axis ();
    assign axis.tready = rdy;
    axi4_stream_pkt_gen dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .pkt_size_i(size),
        .pkts_amount_i(amt), .gap_i(gap), .tdest_i(dest), .tid_i(id),
        .busy_o(busy), .pkts_sent_o(sent), .pkt_o(axis)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    beat_t held;
    bit    stalled = 1'b0;
    int    idle = 0;
    always @(negedge clk) begin
        beat_t a, e;
        a = '{axis.tdata, axis.tkeep, axis.tlast, axis.tuser[0], axis.tdest, axis.tid, idle};
        if (!mon_en) begin
            stalled = 1'b0;
            idle = 0;
        end else begin
            if (stalled) begin
                checks++;
                if (!axis.tvalid || a.data !== held.data || a.keep !== held.keep || a.last !== held.last || a.user !== held.user || axis.tstrb !== held.keep) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%h k=%h l=%0b u=%0b expected v=1 d=%h k=%h l=%0b u=%0b",
                             axis.tvalid, a.data, a.keep, a.last, a.user, held.data, held.keep, held.last, held.user);
                end
            end
            if (axis.tvalid && axis.tready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got d=%h expected no beat", a.data);
                end else begin
                    e = q.pop_front();
                    if (a.data !== e.data || a.keep !== e.keep || axis.tstrb !== e.keep || a.last !== e.last || a.user !== e.user
                        || a.dest !== e.dest || a.id !== e.id || (e.gap >= 0 && idle != e.gap)) begin
                        errors++;
                        $display("FAIL beat: got d=%h k=%h s=%h l=%0b u=%0b dst=%0b id=%0b idle=%0d expected d=%h k=%h l=%0b u=%0b dst=%0b id=%0b idle=%0d",
                                 a.data, a.keep, axis.tstrb, a.last, a.user, a.dest, a.id, idle, e.data, e.keep, e.last, e.user, e.dest, e.id, e.gap);
                    end
                end
                idle = 0;
            end else if (!axis.tvalid) idle++;
            stalled = axis.tvalid && !axis.tready;
            held = a;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u, input int g);
        q.push_back('{d, k, l, u, dest, id, g});
    endtask
    task automatic push_pkt(input int p, input int sz, input int g);
        int          nwords;
        logic [31:0] d;
        nwords = (sz + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(p + w * 4 + k);
            push(d, (w == nwords - 1 && sz % 4 != 0) ? 4'((1 << (sz % 4)) - 1) : 4'hf,
                 w == nwords - 1, w == 0, w == 0 ? g : 0);
        end
    endtask
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask
    initial begin
        tick();
        tick();
        check("rst_tvalid", 32'(axis.tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent", 32'(sent), 32'd0);
        check("rst_tdata", axis.tdata, 32'd0);
        rst = 1'b0;
        tick();
        size = 12'd0;
        do_start();
        check("zero_size_ignored", 32'(busy), 32'd0);
        size = 12'd2049;
        do_start();
        check("oversize_ignored", 32'(busy), 32'd0);
        size = 12'd10; amt = 16'd1; gap = 8'd0; dest = 1'b1; id = 1'b1;
        push(32'h03020100, 4'hf, 1'b0, 1'b1, -1);
        push(32'h07060504, 4'hf, 1'b0, 1'b0, 0);
        push(32'h0B0A0908, 4'h3, 1'b1, 1'b0, 0);
        do_start();
        check("t1_tvalid_latency", 32'(axis.tvalid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("t1_busy_mid", 32'(busy), 32'd1);
        tick();
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_sent", 32'(sent), 32'd1);
        check("t1_queue", 32'(q.size()), 32'd0);
        size = 12'd8; amt = 16'd3; gap = 8'd2; dest = 1'b0; id = 1'b1;
        push_pkt(0, 8, -1);
        push_pkt(1, 8, 2);
        push_pkt(2, 8, 2);
        do_start();
        size = 12'd4; amt = 16'd1; gap = 8'd0; dest = 1'b1; id = 1'b0;
        dest = 1'b0; id = 1'b1;
        wait_idle(100);
        check("t2_sent", 32'(sent), 32'd3);
        check("t2_queue", 32'(q.size()), 32'd0);
        size = 12'd4; amt = 16'd4; gap = 8'd0; dest = 1'b1; id = 1'b0;
        for (int p = 0; p < 4; p++) push_pkt(p, 4, p == 0 ? -1 : 0);
        do_start();
        wait_idle(100);
        check("t3_sent", 32'(sent), 32'd4);
        check("t3_queue", 32'(q.size()), 32'd0);
        size = 12'd12; amt = 16'd1; gap = 8'd0; dest = 1'b0; id = 1'b0;
        push_pkt(0, 12, -1);
        rand_rdy = 1'b1;
        do_start();
        wait_idle(200);
        rand_rdy = 1'b0;
        check("t4_sent", 32'(sent), 32'd1);
        check("t4_queue", 32'(q.size()), 32'd0);
        size = 12'd8; amt = 16'd0; gap = 8'd0; dest = 1'b1; id = 1'b1;
        for (int p = 0; p < 6; p++) push_pkt(p, 8, p == 0 ? -1 : 0);
        do_start();
        begin
            int n = 0;
            while (!(axis.tvalid && axis.tlast && axis.tdata[7:0] == 8'h09) && n < 200) begin
                tick();
                n++;
            end
            check("t5_stop_window", 32'(n < 200), 32'd1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(50);
        check("t5_sent", 32'(sent), 32'd6);
        check("t5_queue", 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        size = 12'd16; amt = 16'd1;
        do_start();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_tvalid", 32'(axis.tvalid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        size = 12'd4; amt = 16'd1; dest = 1'b0; id = 1'b0;
        push(32'h03020100, 4'hf, 1'b1, 1'b1, -1);
        do_start();
        wait_idle(50);
        check("t6_sent", 32'(sent), 32'd1);
        check("t6_queue", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
